// File: rtl/xbus_vec_gather.sv
// Lockstep gather of P lane FIFOs into one P*S-byte vector stream with a
// 2-entry skid buffer that hides the FIFO read latency under backpressure.
module xbus_vec_gather #(
  parameter int P     = 4,
  parameter int S     = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_vecs,
  output logic               busy,
  output logic               done,
  output logic [P-1:0]       fifo_rd_en,
  input  logic [P*S*8-1:0]   fifo_dout,
  input  logic [P-1:0]       fifo_empty,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [P*S*8-1:0]   m_data,
  output logic               m_last
);

  localparam int VW = P * S * 8;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, issued_q, delivered_q;
  logic             inflight_q;
  logic [1:0]       occ_q;
  logic [VW-1:0]    buf0_q, buf1_q;

  logic             hs, issue, last_beat;
  logic [2:0]       credit_used;

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf0_q;
  assign hs        = m_valid & m_ready;
  assign last_beat = (delivered_q == n_q - CNT_W'(1));
  assign m_last    = m_valid & last_beat;

  // Entries held or already on their way, less the one leaving this cycle.
  assign credit_used = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, hs};
  assign issue = (state_q == RUN) && (fifo_empty == '0) &&
                 (issued_q < n_q) && (credit_used < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (n_vecs == '0) ? FIN : RUN;
      RUN:     if (hs && last_beat) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    fifo_rd_en = '0;
    case (state_q)
      RUN: begin
        busy       = 1'b1;
        fifo_rd_en = {P{issue}};
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q         <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        n_q         <= n_vecs;
        issued_q    <= '0;
        delivered_q <= '0;
      end else begin
        if (issue) issued_q    <= issued_q + CNT_W'(1);
        if (hs)    delivered_q <= delivered_q + CNT_W'(1);
      end
      inflight_q <= issue;
    end
  end

  // Returning read data lands at the tail; a handshake retires the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      case ({inflight_q, hs})
        2'b10: begin
          if (occ_q == 2'd0) buf0_q <= fifo_dout;
          else               buf1_q <= fifo_dout;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          buf0_q <= buf1_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_q <= fifo_dout;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    inflight_q |-> (occ_q != 2'd2));

endmodule

// File: tb/tb_xbus_vec_gather.sv
// Randomised bench for xbus_vec_gather: lane FIFO environment, queue-based
// reference model compared every cycle, plus pinned per-job expectations.
module tb_xbus_vec_gather;
  localparam int P = 4, S = 4, CNT_W = 4, LW = S * 8, VW = P * LW;

  logic             clk = 1'b0;
  logic             rst, start, m_ready;
  logic [CNT_W-1:0] n_vecs;
  logic             busy, done, m_valid, m_last;
  logic [P-1:0]     fifo_rd_en, fifo_empty;
  logic [VW-1:0]    fifo_dout, m_data;

  always #5 clk = ~clk;

  xbus_vec_gather #(.P(P), .S(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_vecs(n_vecs), .busy(busy), .done(done),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last));

  logic [LW-1:0] lane_q [P][$];
  int push_cnt [P];
  int pop_cnt  [P];
  int need     [P];

  int            md_mode, md_n, md_iss, md_del;
  bit            md_infl;
  logic [VW-1:0] md_infl_d;
  logic [VW-1:0] md_buf [$];

  bit            e_valid, e_last, e_busy, e_done, e_rd, e_hs;
  logic [P-1:0]  smp_rd;
  bit            prev_stall;
  logic [VW-1:0] prev_data;

  int            cyc, obs_rd, obs_done_cyc, obs_first_rd, obs_first_valid, obs_last_idx, obs_last_hs;
  logic [VW-1:0] obs_vecs [$];
  int            tests, fails;

  function automatic logic [LW-1:0] wd(int i, int k);
    return LW'((i << 16) | (k & 16'hFFFF));
  endfunction

  task automatic chk(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic upd_empty();
    for (int i = 0; i < P; i++) fifo_empty[i] = (lane_q[i].size() == 0);
  endtask

  task automatic push(int i, logic [LW-1:0] w);
    lane_q[i].push_back(w);
    push_cnt[i]++;
    upd_empty();
  endtask

  task automatic push_n(int i, int cnt);
    for (int k = 0; k < cnt; k++) push(i, wd(i, push_cnt[i]));
  endtask

  task automatic model_reset();
    md_mode = 0; md_n = 0; md_iss = 0; md_del = 0; md_infl = 0;
    md_infl_d = '0;
    md_buf.delete();
    prev_stall = 0;
  endtask

  // Expected outputs this cycle from the block's rules and the current inputs.
  task automatic model_eval();
    e_valid = (md_buf.size() != 0);
    e_hs    = e_valid && m_ready;
    e_last  = e_valid && (md_del == md_n - 1);
    e_busy  = (md_mode == 1);
    e_done  = (md_mode == 2);
    e_rd    = (md_mode == 1) && (fifo_empty == '0) && (md_iss < md_n) &&
              (md_buf.size() + int'(md_infl) - int'(e_hs) < 2);
  endtask

  task automatic check_cycle();
    model_eval();
    chk("busy", VW'(busy), VW'(e_busy));
    chk("done", VW'(done), VW'(e_done));
    chk("rd_en", VW'(fifo_rd_en), VW'({P{e_rd}}));
    chk("m_valid", VW'(m_valid), VW'(e_valid));
    chk("m_last", VW'(m_last), VW'(e_last));
    if (e_valid) chk("m_data", m_data, md_buf[0]);
    if (prev_stall) chk("hold_data", m_data, prev_data);
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    smp_rd = fifo_rd_en;
    if (|fifo_rd_en) begin
      obs_rd++;
      if (obs_first_rd < 0) obs_first_rd = cyc;
    end
    if (m_valid && obs_first_valid < 0) obs_first_valid = cyc;
    if (m_valid && m_ready) begin
      if (m_last) obs_last_idx = obs_vecs.size();
      obs_vecs.push_back(m_data);
      obs_last_hs = cyc;
    end
    if (done) obs_done_cyc = cyc;
  endtask

  task automatic advance();
    logic [VW-1:0] nd;
    nd = '0;
    if (e_rd) for (int i = 0; i < P; i++) nd[i*LW +: LW] = lane_q[i][0];
    for (int i = 0; i < P; i++)
      if (smp_rd[i] && lane_q[i].size() != 0) begin
        fifo_dout[i*LW +: LW] = lane_q[i].pop_front();
        pop_cnt[i]++;
      end
    if (rst) begin
      model_reset();
    end else begin
      if (e_hs) void'(md_buf.pop_front());
      if (md_infl) md_buf.push_back(md_infl_d);
      md_infl   = e_rd;
      md_infl_d = nd;
      md_iss   += int'(e_rd);
      md_del   += int'(e_hs);
      case (md_mode)
        0: if (start) begin
             md_n = int'(n_vecs); md_iss = 0; md_del = 0;
             md_mode = (n_vecs == '0) ? 2 : 1;
           end
        1: if (e_hs && e_last) md_mode = 2;
        default: md_mode = 0;
      endcase
    end
    cyc++;
    upd_empty();
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic start_job(int n);
    obs_rd = 0; obs_done_cyc = -1; obs_first_rd = -1; obs_first_valid = -1;
    obs_last_idx = -1; obs_last_hs = -1;
    obs_vecs.delete();
    n_vecs = CNT_W'(n);
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic run_until_done(int budget, int rmode, bit rnd_push);
    int c;
    c = 0;
    while (obs_done_cyc < 0 && c < budget) begin
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (c % 4 == 0) || (c % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (rnd_push)
        for (int i = 0; i < P; i++)
          if (need[i] > 0 && $urandom_range(0, 1) == 1) begin
            push(i, LW'($urandom));
            need[i]--;
          end
      step();
      c++;
    end
    if (obs_done_cyc < 0) begin
      tests++; fails++;
      $display("FAIL job_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic chk_vecs(string name, int n, int base);
    chk({name, "_count"}, VW'(obs_vecs.size()), VW'(n));
    for (int j = 0; j < n && j < obs_vecs.size(); j++)
      for (int i = 0; i < P; i++)
        chk({name, "_lane"}, VW'(obs_vecs[j][i*LW +: LW]), VW'(wd(i, base + j)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, s, c;
    int pops0 [P];
    tests = 0; fails = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; n_vecs = '0; m_ready = 1'b0; fifo_dout = '0;
    for (int i = 0; i < P; i++) begin push_cnt[i] = 0; pop_cnt[i] = 0; need[i] = 0; end
    upd_empty();
    model_reset();
    smp_rd = '0;
    #1;
    chk("rst_busy", VW'(busy), '0);
    chk("rst_done", VW'(done), '0);
    chk("rst_valid", VW'(m_valid), '0);
    chk("rst_last", VW'(m_last), '0);
    chk("rst_rd_en", VW'(fifo_rd_en), '0);
    chk("rst_data", m_data, '0);
    step(); step();
    rst = 1'b0;
    step();

    // Pre-filled lanes, streaming at full rate.
    for (int i = 0; i < P; i++) push_n(i, 4);
    base = pop_cnt[0];
    m_ready = 1'b1;
    start_job(4);
    run_until_done(40, 0, 0);
    chk_vecs("t1", 4, base);
    chk("t1_rd_pulses", VW'(obs_rd), VW'(4));
    chk("t1_last_idx", VW'(obs_last_idx), VW'(3));
    chk("t1_done_after_last", VW'(obs_done_cyc), VW'(obs_last_hs + 1));
    chk("t1_first_valid", VW'(obs_first_valid), VW'(obs_first_rd + 2));
    chk("t1_back_to_back", VW'(obs_last_hs - obs_first_valid), VW'(3));

    // One lane empty blocks every lane.
    for (int i = 0; i < 3; i++) push_n(i, 2);
    base = pop_cnt[0];
    start_job(2);
    repeat (6) step();
    chk("t2_no_rd", VW'(obs_rd), '0);
    chk("t2_no_valid", VW'(obs_first_valid), VW'(-1));
    push_n(3, 2);
    run_until_done(30, 0, 0);
    chk_vecs("t2", 2, base);

    // Backpressure 1,0,0,1.
    for (int i = 0; i < P; i++) begin push_n(i, 8); pops0[i] = pop_cnt[i]; end
    base = pop_cnt[0];
    start_job(8);
    run_until_done(80, 1, 0);
    chk_vecs("t3", 8, base);
    for (int i = 0; i < P; i++) chk("t3_pops", VW'(pop_cnt[i] - pops0[i]), VW'(8));

    // Zero-length job.
    m_ready = 1'b1;
    s = cyc;
    start_job(0);
    run_until_done(10, 0, 0);
    chk("t4_done_cycle", VW'(obs_done_cyc), VW'(s + 1));
    chk("t4_no_rd", VW'(obs_rd), '0);
    chk("t4_no_valid", VW'(obs_first_valid), VW'(-1));

    // start during RUN is ignored.
    for (int i = 0; i < P; i++) push_n(i, 5);
    start_job(5);
    step(); step();
    n_vecs = CNT_W'(9); start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(40, 0, 0);
    chk("t6_count", VW'(obs_vecs.size()), VW'(5));
    chk("t6_rd_pulses", VW'(obs_rd), VW'(5));

    // Reset mid-job, then a fresh single-vector job.
    for (int i = 0; i < P; i++) push_n(i, 10);
    start_job(10);
    c = 0;
    while (obs_vecs.size() < 3 && c < 30) begin step(); c++; end
    rst = 1'b1;
    #1;
    chk("t5_busy", VW'(busy), '0);
    chk("t5_valid", VW'(m_valid), '0);
    chk("t5_last", VW'(m_last), '0);
    chk("t5_rd_en", VW'(fifo_rd_en), '0);
    chk("t5_data", m_data, '0);
    model_reset();
    step(); step();
    rst = 1'b0;
    base = pop_cnt[0];
    start_job(1);
    run_until_done(20, 0, 0);
    chk_vecs("t5", 1, base);
    chk("t5_last_idx", VW'(obs_last_idx), '0);

    // Random jobs with random data arrival and backpressure.
    for (int j = 0; j < 6; j++) begin
      int n;
      n = $urandom_range(1, 15);
      for (int i = 0; i < P; i++) need[i] = n;
      start_job(n);
      run_until_done(400, 2, 1);
      chk("rnd_count", VW'(obs_vecs.size()), VW'(n));
    end

    // Maximum count for the counter width.
    for (int i = 0; i < P; i++) push_n(i, 15);
    start_job(15);
    run_until_done(100, 0, 0);
    chk("max_count", VW'(obs_vecs.size()), VW'(15));
    chk("max_rd", VW'(obs_rd), VW'(15));
    chk("max_last_idx", VW'(obs_last_idx), VW'(14));

    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
